intr_ctrl: RTL
==============

Name: intr_ctrl

Overview:
- Interrupt controller feeding the control unit's interrupt inputs. It latches edge-triggered requests on N lines and presents the highest-priority pending unmasked request on min_bit_s. It tracks nested in-service levels and presents the current level on min_bit_a.
- It consumes the control unit's acknowledge (s_intr with s_call_intr) and end-of-interrupt (s_intr with s_return_intr, issued by JRINTR) to update its state. It is the responder end of the uc interrupt handshake.

Parameters:
- N, 8, number of interrupt lines. Must equal the uc vector width of 8.
- SYNC_STAGES, 2, synchroniser flops per irq line. Legal range 0..3. 0 means irq is already synchronous.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- irq  in  N  raw interrupt request lines; a rising edge requests service.
- mask_we  in  1  loads mask_din into the mask register.
- mask_din  in  N  new mask value; 1 = line masked.
- s_intr  in  1  from uc; qualifies s_call_intr and s_return_intr.
- s_call_intr  in  N  from uc; one-hot acknowledge of the vectored request.
- s_return_intr  in  N  from uc; one-hot end-of-interrupt for the returning level.
- min_bit_s  out  N  one-hot highest-priority pending unmasked request; 0 = none.
- min_bit_a  out  N  one-hot highest-priority in-service level; 0 = none active.
- pending  out  N  pending register, for debug/status.
- in_service  out  N  in-service register.
- spurious  out  1  one-cycle pulse on a protocol error.

Behaviour:
- Priority: bit 0 is highest, bit N-1 is lowest. This matches uc's numeric compare min_bit_s < min_bit_a on one-hot vectors.
- Reset (reset==0 at a clk edge) clears:
  - pending, in_service and all synchroniser/edge flops;
  - mask is set to all-zero (all lines enabled);
  - spurious = 0.
  - All outputs therefore read 0 the cycle after reset.
  - Reset mid-interrupt drops all nesting state; no end-of-interrupt is required afterwards.
- Synchroniser: irq passes through SYNC_STAGES flops to give irq_s. The edge-detect flop irq_p holds the previous irq_s.
- Edge detect: rise = irq_s & ~irq_p. A line held high generates exactly one request; it must go low for at least one sampled cycle to re-arm.
- Latency: irq first sampled high at edge t sets pending at edge t+SYNC_STAGES. min_bit_s reflects it in the same cycle, with no extra register.
- min_bit_s = lowest set bit of (pending & ~mask), as one-hot; 0 if the set is empty. Purely combinational from registers.
- min_bit_a = lowest set bit of in_service, as one-hot; 0 if empty. Purely combinational from registers.
- Acknowledge: on s_intr==1 with s_call_intr!=0 at a clk edge:
  - pending &= ~s_call_intr;
  - in_service |= s_call_intr.
- End of interrupt: on s_intr==1 with s_return_intr!=0 at a clk edge: in_service &= ~s_return_intr.
- Both call and return vectors nonzero in one cycle: both updates apply, return first, then call.
- Next-state order per bit:
  - pending_next = (pending & ~ack) | rise. A new edge on the same line as an ack keeps that line pending.
  - in_service_next = (in_service & ~eoi) | ack.
- Masking affects only min_bit_s. Masked lines still latch pending and are presented once unmasked. mask_we takes effect at the next edge.
- Protocol errors: spurious pulses high for exactly one cycle after the edge at which either occurs. State still updates per the rules above.
  - s_call_intr is not one-hot, or names a bit not set in (pending & ~mask).
  - s_return_intr names a bit not set in in_service.
- s_intr==1 with both vectors 0 is ignored, with no spurious.
- Nesting depth is bounded only by N, one level per line. A line already in service can be pending again; uc only takes it if it has higher priority than the current min_bit_a.

Test Plan:
- Reset/idle: hold reset=0 for 3 cycles with irq=8'hFF → pending, in_service, min_bit_s, min_bit_a and spurious all 0. Release reset, irq=0 → outputs stay 0.
- Single request, SYNC_STAGES=2: irq[3] rises, first sampled at edge t → pending=8'h08 and min_bit_s=8'h08 after edge t+2. Ack with s_intr=1, s_call_intr=8'h08 → pending=0, in_service=8'h08, min_bit_a=8'h08. EOI with s_return_intr=8'h08 → in_service=0.
- Priority/nesting: pend irq[5] and irq[2] together → min_bit_s=8'h04. Ack 8'h04 → min_bit_s=8'h20, min_bit_a=8'h04. Raise irq[0] → min_bit_s=8'h01; ack → in_service=8'h05, min_bit_a=8'h01. EOI 8'h01 → min_bit_a=8'h04.
- Mask: mask_din=8'h10 with mask_we, then irq[4] rises → pending=8'h10, min_bit_s=0. Write mask 0 → min_bit_s=8'h10 the next cycle.
- Simultaneous edge and ack on line 1: new irq[1] edge arrives at the same edge as ack 8'h02 → pending[1] stays 1 and in_service[1]=1. Level-held irq[1] produces no further pending after the next ack.
- Spurious: s_return_intr=8'h40 with in_service=0 → spurious=1 for exactly one cycle, in_service stays 0. s_call_intr=8'h03 → spurious=1.

Source files
------------

// File: rtl/intr_ctrl.sv
// Vectored interrupt controller: latches irq rising edges, presents the
//   highest-priority pending unmasked line and the current in-service level.
// Latency: irq to pending takes SYNC_STAGES edges; min_bit_s/min_bit_a are
//   combinational from registers. No backpressure: ack/eoi are taken every cycle.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-low reset
//   irq               raw request lines, rising edge requests service
//   mask_we/mask_din  mask register load (1 = line masked)
//   s_intr, s_call_intr, s_return_intr   acknowledge / end-of-interrupt from uc
//   min_bit_s         one-hot highest-priority pending unmasked request
//   min_bit_a         one-hot highest-priority in-service level
//   pending, in_service   status registers
//   spurious          one-cycle pulse after a protocol error
module intr_ctrl #(
  parameter int N           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] irq,
  input  logic         mask_we,
  input  logic [N-1:0] mask_din,
  input  logic         s_intr,
  input  logic [N-1:0] s_call_intr,
  input  logic [N-1:0] s_return_intr,
  output logic [N-1:0] min_bit_s,
  output logic [N-1:0] min_bit_a,
  output logic [N-1:0] pending,
  output logic [N-1:0] in_service,
  output logic         spurious
);

  logic [N-1:0] irq_s;

  // Synchroniser chain; with zero stages irq is taken as already synchronous.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign irq_s = irq;
    end else begin : g_sync
      logic [N-1:0] sync_q [SYNC_STAGES];
      logic [N-1:0] sync_d [SYNC_STAGES];

      always_comb begin
        sync_d[0] = irq;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          sync_d[i] = sync_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        for (int i = 0; i < SYNC_STAGES; i++) begin
          if (!reset) begin
            sync_q[i] <= '0;
          end else begin
            sync_q[i] <= sync_d[i];
          end
        end
      end

      assign irq_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  logic [N-1:0] irq_p_q, irq_p_d;
  logic [N-1:0] pending_q, pending_d;
  logic [N-1:0] in_service_q, in_service_d;
  logic [N-1:0] mask_q, mask_d;
  logic         spurious_q, spurious_d;

  logic [N-1:0] rise;
  logic [N-1:0] ack;
  logic [N-1:0] eoi;
  logic [N-1:0] enabled;
  logic         call_bad;
  logic         ret_bad;

  always_comb begin
    ack      = s_intr ? s_call_intr   : '0;
    eoi      = s_intr ? s_return_intr : '0;
    rise     = irq_s & ~irq_p_q;
    enabled  = pending_q & ~mask_q;

    // An ack must be one-hot (x & (x-1) clears the lowest set bit) and name
    // a line that was actually being presented.
    call_bad = (ack != '0) &&
               (((ack & (ack - N'(1))) != '0) || ((ack & ~enabled) != '0));
    ret_bad  = (eoi & ~in_service_q) != '0;

    irq_p_d      = irq_s;
    // A fresh edge on a line being acknowledged keeps that line pending.
    pending_d    = (pending_q & ~ack) | rise;
    // Return is applied before call so a same-cycle re-entry stays in service.
    in_service_d = (in_service_q & ~eoi) | ack;
    mask_d       = mask_we ? mask_din : mask_q;
    spurious_d   = call_bad || ret_bad;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      irq_p_q      <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      mask_q       <= '0;
      spurious_q   <= 1'b0;
    end else begin
      irq_p_q      <= irq_p_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      mask_q       <= mask_d;
      spurious_q   <= spurious_d;
    end
  end

  // Lowest set bit isolated as one-hot: x & -x. Bit 0 is highest priority.
  assign min_bit_s  = enabled & (~enabled + N'(1));
  assign min_bit_a  = in_service_q & (~in_service_q + N'(1));
  assign pending    = pending_q;
  assign in_service = in_service_q;
  assign spurious   = spurious_q;

endmodule
